// File: rtl/mem_mode_sequencer.sv
// mem_mode_sequencer: owns the single-port data memory and time-shares it between
// the UART receiver (load), the UART transmitter (dump) and the image processor (run).
//
// Handshake semantics: cmd_*, rx_done_tick, tx_done_tick and cpu_done are
// single-cycle pulses sampled on the rising clock edge with no backpressure;
// tx_start is a single-cycle request and tx_done_tick later marks the byte as sent.
module mem_mode_sequencer #(
    parameter int LEN    = 16384,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_dump,
    input  logic              cmd_run,
    input  logic              cmd_idle,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done_tick,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_clk_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [7:0]        led,
    output logic [2:0]        dbg_state
);

    // count needs one extra bit so it can hold LEN itself without wrapping
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_DUMP_RD   = 3'd3,
        S_DUMP_WT   = 3'd4,
        S_DUMP_SEND = 3'd5,
        S_DUMP_WTX  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_en_q, mem_en_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              clk_en_q, clk_en_d;
    logic [7:0]        led_q, led_d;
    logic              cmd_any;
    logic              run_mode;

    assign cmd_any  = cmd_idle | cmd_load | cmd_dump | cmd_run;
    assign run_mode = (state_q == S_RUN);

    // Next-state and next registered-output logic; abort has top priority
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_en_d    = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        done_d      = 1'b0;
        // the completion pattern on the LEDs holds until the next command pulse
        hold_d      = hold_q & ~cmd_any;

        if (cmd_idle) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_load) begin
                        state_d = S_LOAD;
                        count_d = '0;
                    end else if (cmd_dump) begin
                        state_d = S_DUMP_RD;
                        count_d = '0;
                    end else if (cmd_run) begin
                        state_d = S_RUN;
                    end
                end
                S_LOAD: begin
                    if (rx_done_tick) begin
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = DATA_W'(rx_data);
                        mem_we_d    = 1'b1;
                        mem_en_d    = 1'b1;
                        count_d     = count_q + CNT_W'(1);
                        if (count_q == CNT_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            hold_d  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cpu_done) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
                S_DUMP_RD: begin
                    mem_addr_d = count_q[ADDR_W-1:0];
                    mem_en_d   = 1'b1;
                    state_d    = S_DUMP_WT;
                end
                S_DUMP_WT: begin
                    // RAM samples the read address on this edge; data arrives next cycle
                    state_d = S_DUMP_SEND;
                end
                S_DUMP_SEND: begin
                    tx_data_d  = mem_rdata[7:0];
                    tx_start_d = 1'b1;
                    state_d    = S_DUMP_WTX;
                end
                S_DUMP_WTX: begin
                    if (tx_done_tick) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            hold_d  = 1'b1;
                        end else begin
                            state_d = S_DUMP_RD;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end

        // status outputs follow the state being entered so they register in step with it
        mode_d = 2'b00;
        led_d  = 8'h80;
        case (state_d)
            S_LOAD: begin
                mode_d = 2'b01;
                led_d  = 8'hF0;
            end
            S_RUN: begin
                mode_d = 2'b10;
                led_d  = 8'(cpu_addr);
            end
            S_DUMP_RD, S_DUMP_WT, S_DUMP_SEND, S_DUMP_WTX: begin
                mode_d = 2'b11;
                led_d  = 8'h0F;
            end
            default: begin
                mode_d = 2'b00;
                led_d  = 8'h80;
            end
        endcase
        if (hold_d) begin
            led_d = 8'hAA;
        end
        busy_d   = (state_d != S_IDLE);
        clk_en_d = (state_d == S_RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            done_q      <= 1'b0;
            hold_q      <= 1'b0;
            mode_q      <= 2'b00;
            busy_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            led_q       <= 8'h80;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_en_q    <= mem_en_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            clk_en_q    <= clk_en_d;
            led_q       <= led_d;
        end
    end

    // In RUN the processor drives the RAM port directly with no added latency
    assign mem_addr   = run_mode ? cpu_addr  : mem_addr_q;
    assign mem_wdata  = run_mode ? cpu_wdata : mem_wdata_q;
    assign mem_we     = run_mode ? cpu_we    : mem_we_q;
    assign mem_en     = run_mode ? 1'b1      : mem_en_q;
    assign cpu_rdata  = mem_rdata;
    assign cpu_clk_en = clk_en_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign mode       = mode_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign led        = led_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_mode_sequencer.sv
// Directed-plus-random bench for mem_mode_sequencer with a behavioural RAM,
// a UART transmitter model and a write/transmit scoreboard.
module tb_mem_mode_sequencer;

  localparam int LEN = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic          cmd_load, cmd_dump, cmd_run, cmd_idle;
  logic          rx_done_tick;
  logic [7:0]    rx_data;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done_tick = 1'b0;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we, cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_clk_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_en;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    mode;
  logic          busy, done;
  logic [7:0]    led;
  logic [2:0]    dbg_state;

  mem_mode_sequencer #(.LEN(LEN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_load(cmd_load), .cmd_dump(cmd_dump), .cmd_run(cmd_run), .cmd_idle(cmd_idle),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_clk_en(cpu_clk_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata),
    .mode(mode), .busy(busy), .done(done), .led(led), .dbg_state(dbg_state)
  );

  // ---------------- environment: RAM and UART transmitter ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  int uart_d;
  always begin
    @(negedge clk);
    if (tx_start) begin
      uart_d = $urandom_range(1, 12);
      repeat (uart_d) @(posedge clk);
      #1 tx_done_tick = 1'b1;
      @(posedge clk);
      #1 tx_done_tick = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       tx_obs_q[$];
  logic [DW-1:0]    model_ram [0:(1<<AW)-1];
  int               done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [AW+DW-1:0] ent;
  logic             gap_valid = 1'b0;
  int               gap_cyc = 0;
  always @(negedge clk) begin
    if (mem_en && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        ent = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(ent[AW+DW-1:DW]));
        check("write_data", 32'(mem_wdata), 32'(ent[DW-1:0]));
      end
    end
    if (tx_start) begin
      tx_obs_q.push_back(tx_data);
      // a finished byte must lead to the next transmit request exactly 4 cycles later
      if (gap_valid) check("tx_gap", 32'(cyc - gap_cyc), 32'd4);
    end
    if (mode != 2'b11) gap_valid = 1'b0;
    else if (tx_done_tick) begin
      gap_valid = 1'b1;
      gap_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic i, input logic l, input logic d, input logic r);
    cmd_idle = i; cmd_load = l; cmd_dump = d; cmd_run = r;
    tick();
    cmd_idle = 1'b0; cmd_load = 1'b0; cmd_dump = 1'b0; cmd_run = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 600) begin
      tick();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_tx_bytes(input string tag, input int n);
    logic [31:0] obs;
    check(tag, 32'(tx_obs_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      obs = (i < tx_obs_q.size()) ? 32'(tx_obs_q[i]) : 32'hDEAD_BEEF;
      check("tx_byte", obs, 32'(model_ram[i][7:0]));
    end
    tx_obs_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int          k;
  int          bad;
  int          exp_done;
  logic [7:0]  bval;
  logic [AW-1:0] wa [4];
  logic [DW-1:0] wd;

  initial begin
    reset = 1'b0;
    cmd_load = 0; cmd_dump = 0; cmd_run = 0; cmd_idle = 0;
    rx_done_tick = 0; rx_data = 8'h00;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 0; cpu_done = 0;
    exp_done = 0;

    // reset values
    tick(2);
    check("rst_mode", 32'(mode), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_clk_en", 32'(cpu_clk_en), 0);
    check("rst_led", 32'(led), 32'h80);
    reset = 1'b1;
    tick();

    // load then dump: first pass uses 11,22,33,44, second pass random bytes
    for (int it = 0; it < 2; it++) begin
      pulse(0, 1, 0, 0);
      check("load_mode", 32'(mode), 32'd1);
      check("load_busy", 32'(busy), 1);
      check("load_led", 32'(led), 32'hF0);
      for (int i = 0; i < LEN; i++) begin
        bval = (it == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
        model_ram[i] = DW'(bval);
        exp_q.push_back({AW'(i), DW'(bval)});
        rx_data = bval;
        rx_done_tick = 1'b1;
        tick();
        check("load_we", 32'(mem_we), 1);
        check("load_addr", 32'(mem_addr), 32'(i));
        check("load_wdata", 32'(mem_wdata), 32'(bval));
        if (i == LEN - 1) begin
          check("load_done", 32'(done), 1);
          check("load_end_mode", 32'(mode), 0);
          check("load_end_led", 32'(led), 32'hAA);
        end else begin
          check("load_no_done", 32'(done), 0);
          if ($urandom_range(0, 1) == 1) begin
            rx_done_tick = 1'b0;
            tick($urandom_range(1, 3));
          end
        end
      end
      rx_done_tick = 1'b0;
      exp_done++;
      tick();
      check("done_one_cycle", 32'(done), 0);
      check("led_hold", 32'(led), 32'hAA);
      // a byte after completion must not reach memory
      rx_data = 8'($urandom_range(0, 255));
      rx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
      check("extra_byte_we", 32'(mem_we), 0);
      check("extra_byte_mode", 32'(mode), 0);
      for (int i = 0; i < LEN; i++) check("ram_after_load", 32'(ram[i]), 32'(model_ram[i]));

      pulse(0, 0, 1, 0);
      check("dump_mode", 32'(mode), 32'd3);
      check("dump_led", 32'(led), 32'h0F);
      check("dump_lat0", 32'(tx_start), 0);
      tick();
      check("dump_lat1", 32'(tx_start), 0);
      tick();
      check("dump_lat2", 32'(tx_start), 0);
      tick();
      check("dump_first_start", 32'(tx_start), 1);
      check("dump_first_data", 32'(tx_data), 32'(model_ram[0][7:0]));
      wait_done("dump_done");
      exp_done++;
      check("dump_end_mode", 32'(mode), 0);
      check("dump_end_led", 32'(led), 32'hAA);
      check_tx_bytes("dump_count", LEN);
    end

    // abort a dump after two bytes, then restart from address 0
    pulse(0, 0, 1, 0);
    k = 0;
    while (tx_obs_q.size() < 2 && k < 400) begin
      tick();
      k++;
    end
    check("abort_two_sent", 32'(tx_obs_q.size()), 32'd2);
    pulse(1, 0, 0, 0);
    check("abort_mode", 32'(mode), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_tx_start", 32'(tx_start), 0);
    bad = 0;
    repeat (30) begin
      tick();
      if (tx_start || done || mem_we || cpu_clk_en) bad++;
    end
    check("abort_quiet", 32'(bad), 0);
    check_tx_bytes("abort_count", 2);
    pulse(0, 0, 1, 0);
    wait_done("restart_done");
    exp_done++;
    check_tx_bytes("restart_count", LEN);

    // processor writes outside RUN have no effect
    cpu_addr = AW'(3);
    cpu_wdata = DW'($urandom_range(0, 65535));
    cpu_we = 1'b1;
    tick(3);
    check("idle_cpu_we", 32'(mem_we), 0);
    cpu_we = 1'b0;

    // RUN: processor owns the port
    pulse(0, 0, 0, 1);
    check("run_mode", 32'(mode), 32'd2);
    check("run_clk_en", 32'(cpu_clk_en), 1);
    check("run_busy", 32'(busy), 1);
    for (int j = 0; j < 4; j++) begin
      wa[j] = (j == 0) ? AW'(7) : AW'($urandom_range(8, 255));
      wd = (j == 0) ? 16'hBEEF : DW'($urandom_range(0, 65535));
      model_ram[wa[j]] = wd;
      exp_q.push_back({wa[j], wd});
      cpu_addr = wa[j];
      cpu_wdata = wd;
      cpu_we = 1'b1;
      #1;
      check("run_mux_addr", 32'(mem_addr), 32'(wa[j]));
      check("run_mux_wdata", 32'(mem_wdata), 32'(wd));
      check("run_mux_we", 32'(mem_we), 1);
      check("run_mux_en", 32'(mem_en), 1);
      tick();
    end
    cpu_we = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      cpu_addr = wa[j];
      tick();
      check("run_rdata", 32'(cpu_rdata), 32'(model_ram[wa[j]]));
      check("run_led", 32'(led), 32'(wa[j]));
    end
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    exp_done++;
    check("run_end_mode", 32'(mode), 0);
    check("run_end_done", 32'(done), 1);
    check("run_end_clk_en", 32'(cpu_clk_en), 0);
    check("run_end_led", 32'(led), 32'hAA);
    check("ram7", 32'(ram[7]), 32'hBEEF);

    // command priority
    pulse(0, 1, 0, 1);
    check("prio_load_over_run", 32'(mode), 32'd1);
    check("prio_led", 32'(led), 32'hF0);
    pulse(0, 0, 0, 1);
    check("run_in_load_ignored", 32'(mode), 32'd1);
    bval = 8'($urandom_range(0, 255));
    exp_q.push_back({AW'(0), DW'(bval)});
    model_ram[0] = DW'(bval);
    rx_data = bval;
    rx_done_tick = 1'b1;
    tick();
    check("reentry_addr0", 32'(mem_addr), 0);
    cmd_idle = 1'b1;
    tick();
    cmd_idle = 1'b0;
    rx_done_tick = 1'b0;
    check("abort_beats_rx_mode", 32'(mode), 0);
    check("abort_beats_rx_we", 32'(mem_we), 0);
    check("abort_no_done", 32'(done), 0);
    pulse(1, 1, 0, 0);
    check("prio_idle_over_load", 32'(mode), 0);
    check("prio_idle_busy", 32'(busy), 0);
    check("idle_cmd_led", 32'(led), 32'h80);
    pulse(0, 0, 1, 1);
    check("prio_dump_over_run", 32'(mode), 32'd3);
    pulse(1, 0, 0, 0);
    tick(5);
    check("short_dump_no_tx", 32'(tx_obs_q.size()), 0);

    // asynchronous reset in the middle of a load
    pulse(0, 1, 0, 0);
    bval = 8'($urandom_range(0, 255));
    exp_q.push_back({AW'(0), DW'(bval)});
    model_ram[0] = DW'(bval);
    rx_data = bval;
    rx_done_tick = 1'b1;
    tick();
    rx_data = 8'($urandom_range(0, 255));
    tick();
    check("pre_reset_we", 32'(mem_we), 1);
    #1 reset = 1'b0;
    #1;
    check("async_mode", 32'(mode), 0);
    check("async_busy", 32'(busy), 0);
    check("async_we", 32'(mem_we), 0);
    check("async_en", 32'(mem_en), 0);
    check("async_addr", 32'(mem_addr), 0);
    check("async_wdata", 32'(mem_wdata), 0);
    check("async_led", 32'(led), 32'h80);
    rx_done_tick = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
    check("post_reset_mode", 32'(mode), 0);
    check("ram0_after_reset", 32'(ram[0]), 32'(model_ram[0]));

    tick(3);
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("writes_left", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_mode_sequencer.md
# mem_mode_sequencer

Controller owning the single-port data memory. It time-shares the memory between three users: the UART receiver (PC→RAM load), the UART transmitter (RAM→PC dump) and the image processor (run). It sequences each transfer with proper handshakes, counts bytes and returns to idle on completion or abort. It sits between the debouncer pulses, the UART, the processor and the RAM, and replaces ad-hoc mode muxing at top level.

## Interface
- LEN, 16384: bytes per load/dump transfer (1..2^ADDR_W)
- ADDR_W, 16: memory address width
- DATA_W, 16: memory data width (UART byte zero-extended / low byte taken)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cmd_load, cmd_dump, cmd_run, cmd_idle  in  1 each  single-cycle debounced command pulses
- rx_done_tick  in  1  UART byte received; rx_data  in  8  received byte
- tx_start  out  1  one-cycle transmit request; tx_data  out  8  byte to send; tx_done_tick  in  1  transmit complete
- cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W; cpu_we  in  1; cpu_done  in  1  processor memory port and end-of-program
- cpu_rdata  out  DATA_W  memory read data to processor; cpu_clk_en  out  1  processor clock enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we  out  1; mem_en  out  1; mem_rdata  in  DATA_W  RAM port (synchronous read, 1-cycle latency)
- mode  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 DUMP; busy  out  1  mode≠IDLE
- done  out  1  one-cycle pulse on normal completion of LOAD/DUMP/RUN
- led  out  8  status pattern

## Operation
- Top states IDLE, LOAD, RUN, DUMP. DUMP substates RD, WT, SEND, WTX.
- Commands: cmd_idle is accepted in any state (abort). cmd_load/dump/run are accepted only in IDLE and ignored otherwise. Simultaneous pulses resolve as idle > load > dump > run.
- Entering LOAD or DUMP clears count to 0.
- LOAD: on rx_done_tick, register mem_addr=count, mem_wdata={0,rx_data}, mem_we=1, mem_en=1 for exactly one cycle, then increment count. The write with count=LEN-1 returns to IDLE with done=1. rx_done_tick in other states is ignored.
- DUMP: RD drives mem_addr=count, mem_en=1 → WT (1 cycle) → SEND latches tx_data=mem_rdata[7:0] and pulses tx_start one cycle → WTX waits for tx_done_tick, then increments count. If the new count=LEN, go to IDLE with done; otherwise go to RD. tx_done_tick outside WTX is ignored. mem_we is never asserted in DUMP.
- RUN: memory port is combinationally muxed from the cpu port (mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we, mem_en=1); cpu_rdata=mem_rdata at all times; cpu_clk_en=1. cpu_done → IDLE with done, cpu_clk_en drops the same edge.
- Outside RUN, cpu_we has no effect on memory.
- Abort (cmd_idle) mid-LOAD/DUMP/RUN: next state is IDLE. count cleared; tx_start, mem_we and cpu_clk_en are low from the next cycle. No done pulse. A byte already handed to the UART completes on the line but is not counted.
- led: IDLE 8'h80, LOAD 8'hF0, DUMP 8'h0F, RUN cpu_addr[7:0]. A done pulse latches 8'hAA until the next command.
- count is ADDR_W+1 bits wide to reach LEN without wrap. Addresses never exceed LEN-1.

## Timing
- Reset values: mode=IDLE, busy=0, done=0, tx_start=0, tx_data=0, mem_we=0, mem_en=0, mem_addr=0, mem_wdata=0, cpu_clk_en=0, led=8'h80, count=0.
- Command to mode change: 1 cycle (mode updates on the edge after the pulse).
- LOAD: write strobe on the cycle after rx_done_tick. Back-to-back rx_done_ticks on consecutive cycles are each written.
- DUMP: tx_start asserts 3 cycles after entering RD; next RD follows 1 cycle after tx_done_tick.
- RUN mux is zero-latency; all other outputs are registered.
- done coincides with the first IDLE cycle.

## Test plan
- LEN=4, reset low mid-LOAD → all outputs at reset values asynchronously; after release mode=IDLE.
- LEN=4, cmd_load, send 8'h11,22,33,44 → RAM[0..3]=0x0011..0x0044, done pulse, mode=IDLE, led=8'hAA; a 5th byte writes nothing.
- RAM[0..3] preloaded, cmd_dump, UART model returns tx_done 10 cycles after each tx_start → exactly 4 tx_start pulses with tx_data 11,22,33,44, then done.
- cmd_run, processor writes 0xBEEF to addr 7 then cpu_done → RAM[7]=0xBEEF, cpu_clk_en high only during RUN, done pulse.
- cmd_idle after 2 of 4 dump bytes → IDLE next cycle, no done, tx_start stays low; a following cmd_dump restarts from address 0.
- cmd_load and cmd_run in the same cycle → LOAD; cmd_run during LOAD ignored; cmd_idle together with cmd_load in IDLE → stays IDLE.
